// File: rtl/fifo_burst_reader.sv
// Burst reader: drains an upstream FIFO in bursts of up to BURST_LEN beats onto a
// valid/ready stream, using a 2-entry buffer to absorb the FIFO's one-cycle read latency.
module fifo_burst_reader #(
    parameter int DATA_W    = 16,
    parameter int CNT_W     = 7,
    parameter int BURST_LEN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [CNT_W-1:0]  fifo_count,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    input  logic              flush,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic [15:0]       burst_done_cnt
);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    localparam logic [6:0]  LEN_MAX   = 7'(BURST_LEN);
    localparam logic [31:0] LEN_MAX32 = 32'(BURST_LEN);

    state_t            state_q, state_d;
    logic [6:0]        len_q, len_d;
    logic [6:0]        issued_q, issued_d;
    logic [6:0]        beat_q, beat_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        occ_q, occ_d;
    logic [DATA_W-1:0] buf0_q, buf0_d;
    logic [DATA_W-1:0] buf1_q, buf1_d;
    logic [15:0]       done_cnt_q, done_cnt_d;

    logic [31:0] count_ext;
    logic [2:0]  pending;
    logic        valid;
    logic        pop;
    logic        last;
    logic        rd;

    assign count_ext = 32'(fifo_count);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        issued_d   = issued_q;
        beat_d     = beat_q;
        inflight_d = 1'b0;
        occ_d      = occ_q;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        done_cnt_d = done_cnt_q;

        valid = !rst && (occ_q != 2'd0);
        pop   = valid && m_ready;
        last  = valid && (beat_q == len_q - 7'd1);

        // Words already buffered or on their way, after this cycle's pop, must leave room for one more.
        pending = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
        rd      = !rst && (state_q == BURST) && !fifo_empty
                  && (issued_q < len_q) && (pending <= 3'd1);

        inflight_d = rd;
        if (rd)  issued_d = issued_q + 7'd1;
        if (pop) beat_d   = beat_q + 7'd1;

        unique case ({inflight_q, pop})
            2'b10: begin
                if (occ_q == 2'd0) buf0_d = fifo_data;
                else               buf1_d = fifo_data;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                buf0_d = buf1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd2) begin
                    buf0_d = buf1_q;
                    buf1_d = fifo_data;
                end else begin
                    buf0_d = fifo_data;
                end
            end
            default: ;
        endcase

        unique case (state_q)
            IDLE: begin
                if (count_ext >= LEN_MAX32) begin
                    state_d = BURST;
                    len_d   = LEN_MAX;
                end else if (flush && !fifo_empty) begin
                    // count is below BURST_LEN here, so it fits in 7 bits; never start a zero-length burst
                    state_d = BURST;
                    len_d   = (count_ext == 32'd0) ? 7'd1 : count_ext[6:0];
                end
            end
            BURST: begin
                if (pop && last) begin
                    state_d    = IDLE;
                    done_cnt_d = done_cnt_q + 16'd1;
                    issued_d   = 7'd0;
                    beat_d     = 7'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= 7'd0;
            issued_q   <= 7'd0;
            beat_q     <= 7'd0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            done_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            beat_q     <= beat_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    // Buffer contents are qualified by occupancy, so they carry no reset.
    always_ff @(posedge clk) begin
        buf0_q <= buf0_d;
        buf1_q <= buf1_d;
    end

    assign fifo_rd_en     = rd;
    assign m_valid        = valid;
    assign m_data         = valid ? buf0_q : '0;
    assign m_last         = last;
    assign busy           = !rst && (state_q == BURST);
    assign burst_done_cnt = rst ? 16'd0 : done_cnt_q;

endmodule

// File: doc/fifo_burst_reader.md
FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 Parameter DATA_W, default 16: data word width; SHALL equal the upstream FIFO data width.
REQ-002 Parameter CNT_W, default 7: FIFO occupancy width, covering 0..64.
REQ-003 Parameter BURST_LEN, default 8: maximum beats per burst; legal range 1..64.
REQ-004 Ports SHALL be:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- fifo_empty  in  1  upstream FIFO empty flag.
- fifo_count  in  CNT_W  upstream FIFO occupancy.
- fifo_data  in  DATA_W  upstream FIFO registered read data; valid in the cycle after a read pulse.
- fifo_rd_en  out  1  upstream FIFO pop request.
- flush  in  1  request to drain a partial burst.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accepts beat.
- m_data  out  DATA_W  output beat data.
- m_last  out  1  final beat of the current burst.
- busy  out  1  high while in BURST.
- burst_done_cnt  out  16  completed-burst counter.

Function
REQ-005 FSM states SHALL be IDLE and BURST.
REQ-006 IDLE->BURST SHALL occur on the clock edge where either condition holds:
- fifo_count >= BURST_LEN: burst length BURST_LEN.
- flush=1 and fifo_empty=0: burst length min(fifo_count, BURST_LEN).
REQ-007 The burst length SHALL be latched on entry into BURST and held constant until the burst ends.
REQ-008 flush SHALL be ignored while in BURST.
REQ-009 An internal 2-entry output buffer SHALL hold captured words; one in-flight flag SHALL record a fifo_rd_en issued in the previous cycle.
REQ-010 fifo_rd_en SHALL be combinational and asserted only when all of the following hold:
- state=BURST;
- fifo_empty=0;
- words issued < latched length;
- (buffer occupancy + in-flight − pop this cycle) <= 1.
REQ-011 fifo_data SHALL be written into the buffer on the edge ending the cycle after a fifo_rd_en cycle; m_valid SHALL first rise 2 cycles after the first fifo_rd_en.
REQ-012 A pop SHALL occur when m_valid=1 and m_ready=1; the buffer SHALL be FIFO-ordered; simultaneous capture and pop SHALL be supported in one cycle.
REQ-013 While m_valid=1 and m_ready=0, m_data and m_last SHALL hold stable, and m_valid SHALL not drop.
REQ-014 m_last SHALL be 1 exactly on the beat whose index equals latched length−1; beats SHALL be counted with a 7-bit counter.
REQ-015 On acceptance of the m_last beat, the FSM SHALL go to IDLE, burst_done_cnt SHALL increment (wrapping 0xFFFF->0), and issued/beat counters SHALL clear.
REQ-016 A new burst SHALL be able to start the cycle after returning to IDLE; back-to-back bursts have a 1-cycle IDLE gap minimum.
REQ-017 If fifo_empty rises mid-burst, reading SHALL stall with no over-read; the burst SHALL resume when fifo_empty falls.
REQ-018 busy SHALL equal (state==BURST).

Reset
REQ-019 While rst=1:
- state=IDLE;
- fifo_rd_en=0, m_valid=0, m_last=0, m_data=0, busy=0;
- burst_done_cnt=0;
- buffer, in-flight flag and counters cleared.
REQ-020 Reset mid-burst SHALL discard buffered and in-flight words; no beat SHALL appear after rst deasserts until a new burst starts.
REQ-021 fifo_rd_en SHALL be 0 in the first cycle after rst deasserts.

Verification
REQ-022 fifo_count=8, words 0x0001..0x0008, m_ready=1 -> 8 beats in order; m_last on 0x0008; burst_done_cnt=1; fifo_rd_en pulses exactly 8 times.
REQ-023 fifo_count=3, flush pulse, words 0xA0..0xA2 -> 3 beats; m_last on 0xA2; FSM returns to IDLE.
REQ-024 Burst of 8 with m_ready toggling 1,0,0,1,... -> m_data stable during stalls; buffer occupancy never exceeds 2; no word lost or duplicated.
REQ-025 fifo_empty forced high after beat 4 for 5 cycles -> fifo_rd_en=0 during those cycles; beats 5..8 follow afterward; total is 8 beats.
REQ-026 rst asserted in cycle 3 of a burst -> all outputs 0 next cycle; burst_done_cnt=0; fifo_count=16 then yields two bursts of 8, each with m_last on its 8th beat.
REQ-027 With burst_done_cnt preloaded via 65535 completed BURST_LEN=1 bursts, one further burst -> counter wraps to 0.
